uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter. Successor to the fixed 8N1 transmitter, generalised in frame format.
- Data width, stop-bit count and oversampling factor are compile-time parameters.
- Parity mode is selected at run time, per frame.
- Bit timing advances on an external oversampling tick, not on every clock.
- Upstream logic (sync FIFO read side) hands over words with a valid/ready handshake.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; LSB transmitted first.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
OVERSAMPLING, 16, tick_in pulses per bit period; legal 2..64.

Ports:
clk_in  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous reset, active-high.
tick_in  input  1  oversampling tick; bit-time counter advances only on cycles where tick_in=1.
valid_in  input  1  upstream word available.
data_in  input  DATA_BITS  word to send; sampled on accept.
parity_in  input  2  parity mode, sampled on accept: 00 none, 01 odd, 10 even, 11 mark (always 1).
ready_out  output  1  transmitter can accept a word this cycle.
busy_out  output  1  frame in progress (START..STOP).
tx  output  1  serial line; idle high.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-high.
- While rst=1:
  - state=IDLE, tx=1, ready_out=0, busy_out=0.
  - Counters, data shift register and parity are cleared.
  - ready_out rises on the first clk_in edge after rst deasserts.
- Registered outputs: tx, ready_out and busy_out are all registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, ready_out=1.
  - Accept = valid_in & ready_out on a clock edge.
  - On accept, at that same edge:
    - latch data_in and parity_in;
    - compute the parity bit (odd: ~^data, even: ^data, mark: 1);
    - clear the tick and bit counters;
    - set tx=0, ready_out=0, busy_out=1;
    - go to START.
  - valid_in without ready_out is ignored; upstream holds the word.
- Bit timing:
  - Each bit lasts exactly OVERSAMPLING tick_in pulses, counted from the first tick after the state is entered.
  - The tick counter has width clog2(OVERSAMPLING*STOP_BITS).
  - On the tick where the counter reaches its terminal count, the counter clears and tx updates on that edge.
- START: after OVERSAMPLING ticks, tx=data[0] and go to DATA.
- DATA:
  - Shift right each bit period; the bit counter runs 0..DATA_BITS-1.
  - After the last data bit, go to PARITY if the latched mode≠00, else STOP.
  - tx takes the parity bit or 1 accordingly.
- PARITY: lasts one bit period, then tx=1 and go to STOP.
- STOP:
  - tx=1 for OVERSAMPLING*STOP_BITS ticks.
  - Then go to IDLE with busy_out=0 and ready_out=1 at the same edge.
  - Earliest next start bit: the cycle after that.
- Frame length: (1 + DATA_BITS + (mode≠00) + STOP_BITS) * OVERSAMPLING ticks.
- tick_in held low: the FSM freezes and tx holds its value, with no glitch.
- Input changes mid-frame: changes on data_in or parity_in after accept have no effect on the frame in flight.
- Reset mid-frame: tx returns to 1 asynchronously and the frame is abandoned; no partial stop bit is sent.
- Accept and tick in the same cycle: the tick is not counted toward the start bit.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds port break_in (input, 1).
  - If break_in=1 while in IDLE, tx is driven 0 and ready_out=0 for as long as break_in stays high.
  - A frame already in progress completes normally before the break takes effect.
  - On break_in falling, tx=1 and ready_out=1 at the next edge.
- Not defined: the break_in port does not exist and IDLE behaviour is as above.

Test Plan:
Bench uses OVERSAMPLING=4 with tick_in=1 every cycle unless stated otherwise.
1. 8N1 frame. Reset, then valid_in=1, data_in=0xA5, parity_in=00.
   - Required: accepted on the first IDLE cycle.
   - tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
   - ready_out returns to 1 exactly 40 cycles after accept.
2. Even parity. data_in=0x07, parity_in=10.
   - Required: parity bit=1 (three ones).
   - Frame is 11 bits / 44 cycles.
   - With parity_in=01, parity bit=0.
3. Two stop bits, DATA_BITS=7. STOP_BITS=2, data 0x55, mark parity.
   - Required: the stop level is held 8 ticks.
   - Total frame is 44 ticks; busy_out is high for exactly that span.
4. Tick gating. tick_in pulses every 3rd cycle, data 0xFF.
   - Required: each bit lasts 12 clocks.
   - tx is stable between ticks.
   - Back-to-back valid_in is accepted only while ready_out=1.
5. Reset mid-frame. Assert rst during data bit 3.
   - Required: tx=1, ready_out=0, busy_out=0 immediately.
   - After release: ready_out=1 one edge later, and a fresh frame of 0x3C transmits correctly.
6. Break (only with UART_TX_BREAK_EN). Raise break_in mid-frame for 20 cycles.
   - Required: the current frame finishes.
   - tx is then low for the rest of the break with ready_out=0.
   - tx returns high one edge after break_in falls.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Frame: start bit, DATA_BITS data bits (LSB first), optional parity bit chosen per frame,
// STOP_BITS stop bits. Bit timing advances only on cycles where tick_in is high.
// Optional feature: define UART_TX_BREAK_EN to add the break_in port (line break from IDLE).
module uart_tx_frame #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned OVERSAMPLING = 16
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 tick_in,
   input  logic                 valid_in,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic [1:0]           parity_in,
`ifdef UART_TX_BREAK_EN
   input  logic                 break_in,
`endif
   output logic                 ready_out,
   output logic                 busy_out,
   output logic                 tx
);

   localparam int unsigned TickW = $clog2(OVERSAMPLING * STOP_BITS);
   localparam int unsigned BitW  = $clog2(DATA_BITS);

   localparam logic [TickW-1:0] BitTerm  = TickW'(OVERSAMPLING - 1);
   localparam logic [TickW-1:0] StopTerm = TickW'(OVERSAMPLING * STOP_BITS - 1);
   localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e               state_q;
   logic [TickW-1:0]     tick_cnt_q;
   logic [BitW-1:0]      bit_cnt_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 par_en_q;
   logic                 par_bit_q;

   logic brk;
   logic accept;
   logic tick_last;
   logic par_calc;

`ifdef UART_TX_BREAK_EN
   assign brk = break_in;
`else
   assign brk = 1'b0;
`endif

   // Handshake, terminal-count detect and parity of the word being offered.
   always_comb begin
      accept    = valid_in & ready_out & ~brk;
      tick_last = tick_in &&
                  (tick_cnt_q == ((state_q == StStop) ? StopTerm : BitTerm));
      unique case (parity_in)
         2'b01:   par_calc = ~^data_in;
         2'b10:   par_calc = ^data_in;
         2'b11:   par_calc = 1'b1;
         default: par_calc = 1'b0;
      endcase
   end

   // Frame FSM with registered line and handshake outputs.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         tx         <= 1'b1;
         ready_out  <= 1'b0;
         busy_out   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (brk) begin
                  tx        <= 1'b0;
                  ready_out <= 1'b0;
               end else if (accept) begin
                  shreg_q    <= data_in;
                  par_en_q   <= |parity_in;
                  par_bit_q  <= par_calc;
                  tick_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  tx         <= 1'b0;
                  ready_out  <= 1'b0;
                  busy_out   <= 1'b1;
                  state_q    <= StStart;
               end else begin
                  tx        <= 1'b1;
                  ready_out <= 1'b1;
               end
            end
            StStart, StData, StParity, StStop: begin
               if (tick_in) begin
                  if (tick_last) begin
                     tick_cnt_q <= '0;
                     case (state_q)
                        StStart: begin
                           tx      <= shreg_q[0];
                           state_q <= StData;
                        end
                        StData: begin
                           if (bit_cnt_q == LastBit) begin
                              if (par_en_q) begin
                                 tx      <= par_bit_q;
                                 state_q <= StParity;
                              end else begin
                                 tx      <= 1'b1;
                                 state_q <= StStop;
                              end
                           end else begin
                              shreg_q   <= shreg_q >> 1;
                              tx        <= shreg_q[1];
                              bit_cnt_q <= bit_cnt_q + 1'b1;
                           end
                        end
                        StParity: begin
                           tx      <= 1'b1;
                           state_q <= StStop;
                        end
                        default: begin
                           // End of stop bits: ready again at the same edge.
                           tx        <= 1'b1;
                           ready_out <= 1'b1;
                           busy_out  <= 1'b0;
                           state_q   <= StIdle;
                        end
                     endcase
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
